argmin_n_fp: RTL and testbench
==============================

ARGMIN_N_FP -- requirements
Module: argmin_n_fp

Interface
REQ-001: Parameter N_ACT, default 4, number of IEEE-754 single-precision values per set (legal range 2..16).
REQ-002: Parameter IDX_W, default 2, index width; SHALL equal ceil(log2(N_ACT)).
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: in_valid  input  1  in_data holds a valid value this cycle.
REQ-006: in_ready  output  1  block accepts in_data this cycle.
REQ-007: in_data  input  32  IEEE-754 single-precision operand.
REQ-008: out_valid  output  1  out_min and out_idx hold a valid result.
REQ-009: out_ready  input  1  consumer accepts the result this cycle.
REQ-010: out_min  output  32  minimum value of the completed set.
REQ-011: out_idx  output  IDX_W  arrival position (0-based) of out_min within the set.

Function
REQ-012: An input beat is accepted when in_valid and in_ready are both high on a rising clk edge.
REQ-013: A result is consumed when out_valid and out_ready are both high on a rising clk edge.
REQ-014: The FSM SHALL have three states: S_FIRST (await beat 0), S_ACC (await beats 1..N_ACT-1), S_OUT (hold result).
REQ-015: S_FIRST: in_ready=1; on acceptance, load best=in_data, best_idx=0, cnt=1, go to S_ACC.
REQ-016: S_ACC: in_ready=1; on acceptance, if in_data < best then best=in_data and best_idx=cnt; cnt increments.
REQ-017: S_ACC: the acceptance that makes cnt reach N_ACT SHALL transition to S_OUT, including the compare/update of that beat.
REQ-018: S_OUT: in_ready=0, out_valid=1, out_min=best, out_idx=best_idx; outputs SHALL remain stable until consumed.
REQ-019: S_OUT: on consumption, go to S_FIRST with cnt=0; no input beat is accepted in the consumption cycle.
REQ-020: Latency: out_valid SHALL rise in the cycle immediately after the N_ACT-th beat is accepted.
REQ-021: Compare is purely bitwise, without an adder: signs differ -> the value with sign=1 is smaller, except +0 (0x00000000) and -0 (0x80000000), which are equal.
REQ-022: Compare, both signs 0: the smaller bits[30:0] is smaller.
REQ-023: Compare, both signs 1: the larger bits[30:0] is smaller.
REQ-024: Ties SHALL keep the earlier value and index, so the lowest index wins.
REQ-025: NaN and Inf get no special handling; they are ordered by the REQ-021..023 rules on raw bits.
REQ-026: Outside S_OUT, out_valid=0; out_min and out_idx SHALL be 0.
REQ-027: in_valid deasserted in S_FIRST or S_ACC SHALL stall the FSM, with no state or count change.
REQ-028: in_data SHALL be ignored when in_ready=0.

Reset
REQ-029: rst_n low SHALL immediately force state=S_FIRST, cnt=0, best=0, best_idx=0, out_valid=0, out_min=0, out_idx=0, in_ready=1.
REQ-030: Reset mid-set or mid-S_OUT SHALL discard the partial or pending result; the next accepted beat after release is beat 0.
REQ-031: Beats are accepted from the first rising edge with rst_n high.

Verification
REQ-032: Beats 3F800000, 40000000, BF800000, 3F000000 (1, 2, -1, 0.5) -> next cycle out_valid=1, out_min=BF800000, out_idx=2.
REQ-033: Beats C0000000, BF800000, 00000000, 40000000 -> out_min=C0000000, out_idx=0, which checks the inverted negative magnitude rule.
REQ-034: Beats 3F800000, 80000000, 00000000, 3F800000 -> out_min=80000000, out_idx=1, which checks +0/-0 equality with earliest tie kept.
REQ-035: Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable; then out_ready=1 for 1 cycle -> out_valid=0 and the next set is accepted.
REQ-036: in_valid toggles 1/0 every cycle across a set -> the result is identical to the unstalled case and out_valid rises the cycle after the 4th acceptance.
REQ-037: rst_n pulsed low after 2 beats, then 4 fresh beats 40000000, 3F800000, 40400000, 3F800000 -> out_min=3F800000, out_idx=1, and pre-reset beats do not affect the result.

Source files
------------

// File: rtl/argmin_n_fp.sv
// argmin_n_fp: streaming argmin over sets of N_ACT IEEE-754 single-precision values
module argmin_n_fp #(
    parameter int N_ACT = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_min,
    output logic [IDX_W-1:0] out_idx
);
    localparam int CNT_W = $clog2(N_ACT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ACT - 1);

    typedef enum logic [1:0] {S_FIRST, S_ACC, S_OUT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      best;
    logic [IDX_W-1:0] best_idx;
    logic             accept, consume, take;

    // Strict a < b on raw bits; +0 and -0 compare equal, NaN/Inf ordered like any pattern
    function automatic logic fp_less(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == '0 && b[30:0] == '0) return 1'b0;
        if (a[31] != b[31]) return a[31];
        return a[31] ? (a[30:0] > b[30:0]) : (a[30:0] < b[30:0]);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FIRST;
        else        state <= state_nx;
    end

    // Next state, handshakes and zero-gated result outputs
    always_comb begin
        state_nx  = state;
        in_ready  = state != S_OUT;
        out_valid = state == S_OUT;
        accept    = in_valid && in_ready;
        consume   = out_valid && out_ready;
        take      = accept && (state == S_FIRST || fp_less(in_data, best));
        out_min   = out_valid ? best : '0;
        out_idx   = out_valid ? best_idx : '0;
        case (state)
            S_FIRST: state_nx = accept ? S_ACC : S_FIRST;
            S_ACC:   state_nx = (accept && cnt == LAST) ? S_OUT : S_ACC;
            S_OUT:   state_nx = consume ? S_FIRST : S_OUT;
            default: state_nx = S_FIRST;
        endcase
    end

    // Running minimum, its arrival index and the beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            best     <= '0;
            best_idx <= '0;
        end else if (consume) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= (state == S_FIRST) ? CNT_W'(1) : cnt + CNT_W'(1);
            if (take) begin
                best     <= in_data;
                best_idx <= (state == S_FIRST) ? '0 : cnt[IDX_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_argmin_n_fp.sv
// tb_argmin_n_fp: randomized and directed checks of argmin_n_fp against an order-key model
module tb_argmin_n_fp;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_data = 0;
    logic        in_ready, out_valid;
    logic [31:0] out_min;
    logic [1:0]  out_idx;
    int total = 0, bad = 0;

    argmin_n_fp #(.N_ACT(4), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monotone order key: larger float -> larger unsigned key, both zeros share one key
    function automatic logic [31:0] key(input logic [31:0] v);
        if (v[30:0] == 0) return 32'h8000_0000;
        return v[31] ? ~v : (v | 32'h8000_0000);
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'hFF80_0000;
            4: return {$urandom_range(0, 1) == 1, 8'h3F, 23'($urandom_range(0, 3))};
            default: return $urandom;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_min"}, out_min, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_rdy"}, in_ready, 1);
    endtask

    // mode 0: back-to-back, 1: alternate idle cycles, 2: random idle cycles
    task automatic run_set(input string tag, input logic [31:0] b [4], input int mode, input int hold);
        logic [31:0] emin;
        int          eidx;
        emin = b[0];
        eidx = 0;
        for (int i = 1; i < 4; i++)
            if (key(b[i]) < key(emin)) begin
                emin = b[i];
                eidx = i;
            end
        for (int i = 0; i < 4; i++) begin
            int n;
            n = (i == 0) ? 0 : (mode == 1) ? 1 : (mode == 2) ? $urandom_range(0, 2) : 0;
            repeat (n) begin
                in_valid = 0;
                in_data  = $urandom;
                tick;
                chk({tag, "_stall_ov"}, out_valid, 0);
            end
            in_valid = 1;
            in_data  = b[i];
            chk({tag, "_rdy"}, in_ready, 1);
            tick;
            if (i < 3) chk({tag, "_early_ov"}, out_valid, 0);
        end
        in_valid  = 1;
        in_data   = 32'hFF7F_FFFF;
        out_ready = 0;
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_min"}, out_min, emin);
        chk({tag, "_idx"}, out_idx, eidx);
        repeat (hold) begin
            tick;
            chk({tag, "_hold_ov"}, out_valid, 1);
            chk({tag, "_hold_rdy"}, in_ready, 0);
            chk({tag, "_hold_min"}, out_min, emin);
            chk({tag, "_hold_idx"}, out_idx, eidx);
        end
        out_ready = 1;
        tick;
        out_ready = 0;
        in_valid  = 0;
        check_idle({tag, "_after"});
    endtask

    initial begin
        logic [31:0] s [4];
        #2;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1;
        s = '{32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3F00_0000};
        run_set("basic", s, 0, 0);
        s = '{32'hC000_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4000_0000};
        run_set("neg", s, 0, 0);
        s = '{32'h3F80_0000, 32'h8000_0000, 32'h0000_0000, 32'h3F80_0000};
        run_set("zero", s, 0, 0);
        s = '{32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};
        run_set("hold", s, 0, 5);
        s = '{32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3F00_0000};
        run_set("toggle", s, 1, 0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1;
            in_data  = 32'hC100_0000;
            tick;
        end
        in_valid = 0;
        rst_n    = 0;
        #1;
        check_idle("midset_rst");
        #3;
        rst_n = 1;
        s = '{32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 32'h3F80_0000};
        run_set("post_rst", s, 0, 0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            in_data  = 32'hC100_0000;
            tick;
        end
        in_valid = 0;
        chk("pend_ov", out_valid, 1);
        rst_n = 0;
        #1;
        check_idle("pend_rst");
        #3;
        rst_n = 1;
        s = '{32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000};
        run_set("post_pend", s, 0, 0);
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 4; i++)
                s[i] = (i > 0 && $urandom_range(0, 3) == 0) ? s[$urandom_range(0, i - 1)] : rnd_val();
            run_set("rand", s, 2, $urandom_range(0, 3));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
